// File: rtl/eth_link_rst_mgr.sv
// Link supervisor for the transceiver reset controller: sequences xcvr/MAC resets,
// qualifies lock, reports link_up, and retries with bounded attempts and backoff.
module eth_link_rst_mgr #(
   parameter int RST_HOLD      = 32,
   parameter int READY_TIMEOUT = 65535,
   parameter int LOCK_STABLE   = 256,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int LOSS_FILTER   = 8,
   parameter int MAX_RETRIES   = 7,
   parameter int BACKOFF       = 65535,
   parameter int CNT_W         = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tx_ready,
   input  logic        rx_ready,
   input  logic        rx_is_lockedtodata,
   input  logic        rx_block_lock,
   output logic        xcvr_reset,
   output logic        mac_tx_reset,
   output logic        mac_rx_reset,
   output logic        link_up,
   output logic        fault,
   output logic [2:0]  retry_cnt,
   output logic [15:0] link_drops
);

   localparam logic [CNT_W-1:0] T_HOLD   = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] T_READY  = CNT_W'(READY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] T_STABLE = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] T_LOCK   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] T_LOSS   = CNT_W'(LOSS_FILTER - 1);
   localparam logic [CNT_W-1:0] T_BACK   = CNT_W'(BACKOFF - 1);
   localparam logic [2:0]       MAX_R    = 3'(MAX_RETRIES);

   typedef enum logic [2:0] {
      RST_HOLD_S,
      WAIT_READY,
      WAIT_LOCK,
      LINK_UP,
      FAULT
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t           state, state_nxt;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] stab, stab_nxt;
   logic [CNT_W-1:0] loss, loss_nxt;
   logic [2:0]       retry_nxt;
   logic [15:0]      drops_nxt;
   logic             fail, drop;
   logic             xcvr_nxt, mac_tx_nxt, mac_rx_nxt, link_nxt, fault_nxt;

   // Stage p0/p1: two-flop synchronisers for the asynchronous status inputs
   logic [3:0] sync_p0, sync_p1;
   logic       tx_ok, rx_ok, locked;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= {tx_ready, rx_ready, rx_is_lockedtodata, rx_block_lock};
         sync_p1 <= sync_p0;
      end
   end

   assign tx_ok  = sync_p1[3];
   assign rx_ok  = sync_p1[2];
   assign locked = sync_p1[1] & sync_p1[0];

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      drops_nxt = link_drops;
      stab_nxt  = '0;
      loss_nxt  = '0;
      fail      = 1'b0;
      drop      = 1'b0;
      case (state)
         RST_HOLD_S: if (timer == T_HOLD) state_nxt = WAIT_READY;
         WAIT_READY: begin
            if (tx_ok && rx_ok)        state_nxt = WAIT_LOCK;
            else if (timer == T_READY) fail = 1'b1;
         end
         WAIT_LOCK: begin
            // ready loss outranks stability, stability outranks timeout
            if (!tx_ok || !rx_ok)                 fail = 1'b1;
            else if (locked && stab == T_STABLE)  state_nxt = LINK_UP;
            else begin
               if (locked)           stab_nxt = stab + 1'b1;
               if (timer == T_LOCK)  fail = 1'b1;
            end
         end
         LINK_UP: begin
            if (!tx_ok) drop = 1'b1;
            else if (!(locked && rx_ok)) begin
               if (loss == T_LOSS) drop = 1'b1;
               else                loss_nxt = loss + 1'b1;
            end
         end
         FAULT: begin
            if (timer == T_BACK) begin
               retry_nxt = '0;
               state_nxt = RST_HOLD_S;
            end
         end
         default: state_nxt = RST_HOLD_S;
      endcase

      if (fail) begin
         if (retry_cnt == MAX_R) state_nxt = FAULT;
         else begin
            retry_nxt = retry_cnt + 3'd1;
            state_nxt = RST_HOLD_S;
         end
      end
      if (drop) begin
         state_nxt = RST_HOLD_S;
         drops_nxt = sat_inc16(link_drops);
      end
      if (state_nxt == LINK_UP && state != LINK_UP) retry_nxt = '0;

      // Outputs are registered from the next state so they track the state register
      xcvr_nxt   = (state_nxt == RST_HOLD_S) || (state_nxt == FAULT);
      mac_tx_nxt = (state_nxt == RST_HOLD_S) || (state_nxt == FAULT) || (state_nxt == WAIT_READY);
      mac_rx_nxt = (state_nxt != LINK_UP);
      link_nxt   = (state_nxt == LINK_UP);
      fault_nxt  = (state_nxt == FAULT);
   end

   // Stage p2: state, counters and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= RST_HOLD_S;
         timer        <= '0;
         stab         <= '0;
         loss         <= '0;
         retry_cnt    <= '0;
         link_drops   <= '0;
         xcvr_reset   <= 1'b1;
         mac_tx_reset <= 1'b1;
         mac_rx_reset <= 1'b1;
         link_up      <= 1'b0;
         fault        <= 1'b0;
      end else begin
         state        <= state_nxt;
         timer        <= (state_nxt != state) ? '0 : timer + 1'b1;
         stab         <= stab_nxt;
         loss         <= loss_nxt;
         retry_cnt    <= retry_nxt;
         link_drops   <= drops_nxt;
         xcvr_reset   <= xcvr_nxt;
         mac_tx_reset <= mac_tx_nxt;
         mac_rx_reset <= mac_rx_nxt;
         link_up      <= link_nxt;
         fault        <= fault_nxt;
      end
   end

endmodule

// File: tb/tb_eth_link_rst_mgr.sv
// Directed bench for eth_link_rst_mgr: instance a exercises retry/fault backoff,
// instance b exercises bring-up, loss filtering, drops and reset behaviour.
module tb_eth_link_rst_mgr;

   logic clock, reset;
   logic tx_ready, rx_ready, cdr, blk;

   logic a_xcvr, a_mactx, a_macrx, a_link, a_fault;
   logic [2:0] a_retry;
   logic [15:0] a_drops;
   logic b_xcvr, b_mactx, b_macrx, b_link, b_fault;
   logic [2:0] b_retry;
   logic [15:0] b_drops;

   int tests_run = 0;
   int fails = 0;
   int cyc;

   eth_link_rst_mgr #(
      .RST_HOLD(32), .READY_TIMEOUT(100), .LOCK_STABLE(256), .LOCK_TIMEOUT(2000),
      .LOSS_FILTER(8), .MAX_RETRIES(2), .BACKOFF(50), .CNT_W(20)
   ) u_a (
      .clock(clock), .reset(reset), .tx_ready(tx_ready), .rx_ready(rx_ready),
      .rx_is_lockedtodata(cdr), .rx_block_lock(blk),
      .xcvr_reset(a_xcvr), .mac_tx_reset(a_mactx), .mac_rx_reset(a_macrx),
      .link_up(a_link), .fault(a_fault), .retry_cnt(a_retry), .link_drops(a_drops)
   );

   eth_link_rst_mgr #(
      .RST_HOLD(32), .READY_TIMEOUT(100), .LOCK_STABLE(256), .LOCK_TIMEOUT(2000),
      .LOSS_FILTER(8), .MAX_RETRIES(7), .BACKOFF(50), .CNT_W(20)
   ) u_b (
      .clock(clock), .reset(reset), .tx_ready(tx_ready), .rx_ready(rx_ready),
      .rx_is_lockedtodata(cdr), .rx_block_lock(blk),
      .xcvr_reset(b_xcvr), .mac_tx_reset(b_mactx), .mac_rx_reset(b_macrx),
      .link_up(b_link), .fault(b_fault), .retry_cnt(b_retry), .link_drops(b_drops)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // cycle n = n rising edges after reset release
   always @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tx_ready = 1'b0; rx_ready = 1'b0; cdr = 1'b0; blk = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tx_ready = 1'b0; rx_ready = 1'b0; cdr = 1'b0; blk = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      tests_run++;
      if ({b_xcvr, b_mactx, b_macrx, b_link, b_fault, b_retry, b_drops} !== {5'b11100, 3'd0, 16'd0}) begin
         fails++;
         $display("FAIL reset_b: got %b want %b",
                  {b_xcvr, b_mactx, b_macrx, b_link, b_fault, b_retry, b_drops}, {5'b11100, 3'd0, 16'd0});
      end
      tests_run++;
      if ({a_xcvr, a_mactx, a_macrx, a_link, a_fault, a_retry, a_drops} !== {5'b11100, 3'd0, 16'd0}) begin
         fails++;
         $display("FAIL reset_a: got %b want %b",
                  {a_xcvr, a_mactx, a_macrx, a_link, a_fault, a_retry, a_drops}, {5'b11100, 3'd0, 16'd0});
      end
   endtask

   task automatic test_bringup();
      do_reset();
      goto(31);
      tests_run++;
      if (b_xcvr !== 1'b1) begin fails++; $display("FAIL bringup_xcvr31: got %b want 1", b_xcvr); end
      goto(32);
      tests_run++;
      if ({b_xcvr, b_mactx} !== 2'b01) begin fails++; $display("FAIL bringup_xcvr32: got %b want 01", {b_xcvr, b_mactx}); end
      goto(40);
      tx_ready = 1'b1; rx_ready = 1'b1;
      goto(42);
      tests_run++;
      if (b_mactx !== 1'b1) begin fails++; $display("FAIL bringup_mactx42: got %b want 1", b_mactx); end
      goto(43);
      tests_run++;
      if ({b_mactx, b_macrx} !== 2'b01) begin fails++; $display("FAIL bringup_mactx43: got %b want 01", {b_mactx, b_macrx}); end
      goto(60);
      blk = 1'b1; cdr = 1'b1;
      goto(317);
      tests_run++;
      if (b_link !== 1'b0) begin fails++; $display("FAIL bringup_link317: got %b want 0", b_link); end
      goto(318);
      tests_run++;
      if ({b_link, b_macrx, b_xcvr, b_retry} !== {3'b100, 3'd0}) begin
         fails++; $display("FAIL bringup_link318: got %b want 100000", {b_link, b_macrx, b_xcvr, b_retry});
      end
   endtask

   task automatic test_loss_filter();
      goto(330);
      blk = 1'b0;
      goto(337);
      blk = 1'b1;
      goto(345);
      tests_run++;
      if ({b_link, b_drops} !== {1'b1, 16'd0}) begin
         fails++; $display("FAIL glitch7: got link=%b drops=%0d want link=1 drops=0", b_link, b_drops);
      end
      goto(350);
      blk = 1'b0;
      goto(358);
      blk = 1'b1;
      goto(359);
      tests_run++;
      if (b_link !== 1'b1) begin fails++; $display("FAIL loss8_pre: got link=%b want 1", b_link); end
      goto(360);
      tests_run++;
      if ({b_link, b_xcvr, b_drops} !== {2'b01, 16'd1}) begin
         fails++; $display("FAIL loss8_drop: got link=%b xcvr=%b drops=%0d want 0 1 1", b_link, b_xcvr, b_drops);
      end
      tests_run++;
      if (b_retry !== 3'd0) begin fails++; $display("FAIL loss8_retry: got %0d want 0", b_retry); end
      goto(391);
      tests_run++;
      if (b_xcvr !== 1'b1) begin fails++; $display("FAIL loss8_hold391: got %b want 1", b_xcvr); end
      goto(392);
      tests_run++;
      if (b_xcvr !== 1'b0) begin fails++; $display("FAIL loss8_hold392: got %b want 0", b_xcvr); end
   endtask

   task automatic test_tx_drop();
      int f;
      for (int i = 0; i < 600 && !b_link; i++) begin
         @(posedge clock);
         #1;
      end
      tests_run++;
      if (b_link !== 1'b1) begin fails++; $display("FAIL relink: got link=%b want 1 within 600 cycles", b_link); end
      f = cyc;
      tx_ready = 1'b0;
      goto(f + 1);
      tx_ready = 1'b1;
      goto(f + 2);
      tests_run++;
      if (b_link !== 1'b1) begin fails++; $display("FAIL txdrop_pre: got link=%b want 1", b_link); end
      goto(f + 3);
      tests_run++;
      if ({b_link, b_mactx, b_drops} !== {2'b01, 16'd2}) begin
         fails++; $display("FAIL txdrop: got link=%b mactx=%b drops=%0d want 0 1 2", b_link, b_mactx, b_drops);
      end
   endtask

   task automatic test_ready_glitch();
      do_reset();
      goto(40);
      tx_ready = 1'b1; rx_ready = 1'b1;
      goto(60);
      blk = 1'b1; cdr = 1'b1;
      goto(315);
      rx_ready = 1'b0;
      goto(316);
      rx_ready = 1'b1;
      goto(317);
      tests_run++;
      if ({b_mactx, b_retry} !== {1'b0, 3'd0}) begin
         fails++; $display("FAIL rxglitch_pre: got mactx=%b retry=%0d want 0 0", b_mactx, b_retry);
      end
      goto(318);
      tests_run++;
      if ({b_link, b_xcvr, b_mactx, b_retry} !== {3'b011, 3'd1}) begin
         fails++; $display("FAIL rxglitch_fail: got link=%b xcvr=%b mactx=%b retry=%0d want 0 1 1 1",
                           b_link, b_xcvr, b_mactx, b_retry);
      end
      goto(330);
      tests_run++;
      if (b_link !== 1'b0) begin fails++; $display("FAIL rxglitch_nolink: got %b want 0", b_link); end
   endtask

   task automatic test_ready_timeout_win();
      do_reset();
      goto(129);
      tx_ready = 1'b1; rx_ready = 1'b1;
      goto(131);
      tests_run++;
      if (b_mactx !== 1'b1) begin fails++; $display("FAIL tmowin_pre: got mactx=%b want 1", b_mactx); end
      goto(132);
      tests_run++;
      if ({b_mactx, b_xcvr, b_retry} !== {2'b00, 3'd0}) begin
         fails++; $display("FAIL tmowin: got mactx=%b xcvr=%b retry=%0d want 0 0 0", b_mactx, b_xcvr, b_retry);
      end
   endtask

   task automatic test_retry_fault();
      do_reset();
      goto(131);
      tests_run++;
      if (a_retry !== 3'd0) begin fails++; $display("FAIL retry131: got %0d want 0", a_retry); end
      goto(132);
      tests_run++;
      if ({a_retry, a_xcvr} !== {3'd1, 1'b1}) begin fails++; $display("FAIL retry132: got retry=%0d xcvr=%b want 1 1", a_retry, a_xcvr); end
      goto(264);
      tests_run++;
      if (a_retry !== 3'd2) begin fails++; $display("FAIL retry264: got %0d want 2", a_retry); end
      goto(395);
      tests_run++;
      if (a_fault !== 1'b0) begin fails++; $display("FAIL fault395: got %b want 0", a_fault); end
      goto(396);
      tests_run++;
      if ({a_fault, a_xcvr, a_mactx, a_retry} !== {3'b111, 3'd2}) begin
         fails++; $display("FAIL fault396: got fault=%b xcvr=%b mactx=%b retry=%0d want 1 1 1 2",
                           a_fault, a_xcvr, a_mactx, a_retry);
      end
      goto(445);
      tests_run++;
      if ({a_fault, a_xcvr} !== 2'b11) begin fails++; $display("FAIL fault445: got %b want 11", {a_fault, a_xcvr}); end
      goto(446);
      tests_run++;
      if ({a_fault, a_xcvr, a_retry} !== {2'b01, 3'd0}) begin
         fails++; $display("FAIL fault446: got fault=%b xcvr=%b retry=%0d want 0 1 0", a_fault, a_xcvr, a_retry);
      end
      goto(477);
      tests_run++;
      if (a_xcvr !== 1'b1) begin fails++; $display("FAIL restart477: got %b want 1", a_xcvr); end
      goto(478);
      tests_run++;
      if (a_xcvr !== 1'b0) begin fails++; $display("FAIL restart478: got %b want 0", a_xcvr); end
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      goto(396);
      tests_run++;
      if (b_retry !== 3'd3) begin fails++; $display("FAIL midlock_retry: got %0d want 3", b_retry); end
      goto(400);
      tx_ready = 1'b1; rx_ready = 1'b1;
      goto(440);
      tests_run++;
      if ({b_mactx, b_macrx, b_retry} !== {2'b01, 3'd3}) begin
         fails++; $display("FAIL midlock_state: got mactx=%b macrx=%b retry=%0d want 0 1 3", b_mactx, b_macrx, b_retry);
      end
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if ({b_xcvr, b_mactx, b_macrx, b_link, b_fault, b_retry, b_drops} !== {5'b11100, 3'd0, 16'd0}) begin
         fails++;
         $display("FAIL midlock_reset: got %b want %b",
                  {b_xcvr, b_mactx, b_macrx, b_link, b_fault, b_retry, b_drops}, {5'b11100, 3'd0, 16'd0});
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      tx_ready = 1'b0; rx_ready = 1'b0; cdr = 1'b0; blk = 1'b0;
      test_reset();
      test_bringup();
      test_loss_filter();
      test_tx_drop();
      test_ready_glitch();
      test_ready_timeout_win();
      test_retry_fault();
      test_reset_mid_lock();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
